if_stage: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. It owns the PC, issues one instruction-SRAM read per cycle, and produces the {pc_valid, excp_adef, pc} bus. The bus stays aligned with the SRAM read data that decode captures on the same edge. The stage applies the flush, branch-redirect and stall controls shared by the pipeline, including a branch that arrives while the PC is stalled.

---
 rtl/if_stage.sv | 88 ++++++++
 tb/tb_if_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC ownership, SRAM request, fs_to_ds bus
// The bus always describes the request whose read data decode captures on the same edge.
module if_stage #(
  parameter int          FS_TO_DS_BUS_WD = 34,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                new_pc,
  input  logic [5:0]                 stall,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

  localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        adef_q, adef_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;

  logic [31:0] next_pc;
  logic        fire;
  logic        unused_stall;

  // Only stall[0] belongs to this stage; later-stage bits are ignored.
  assign unused_stall = ^stall[5:1];

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (flush) begin
      next_pc = new_pc;
    end else if (br_taken) begin
      next_pc = br_target;
    end else if (br_pending_q) begin
      next_pc = br_target_q;
    end
  end

  assign fire            = flush | ~stall[0];
  assign inst_sram_addr  = next_pc;
  assign inst_sram_en    = fire & (next_pc[1:0] == 2'b00);
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign fs_to_ds_bus    = FS_TO_DS_BUS_WD'({valid_q, adef_q, pc_q});

  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    adef_d       = adef_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    if (fire) begin
      // Any firing edge consumes (or, on flush, drops) a remembered branch.
      pc_d         = next_pc;
      valid_d      = 1'b1;
      adef_d       = |next_pc[1:0];
      br_pending_d = 1'b0;
    end else if (br_taken) begin
      br_pending_d = 1'b1;
      br_target_d  = br_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= PC_RESET_VAL;
      valid_q      <= 1'b0;
      adef_q       <= 1'b0;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'b0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      adef_q       <= adef_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with directed per-cycle vectors
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] new_pc;
  logic [5:0]  stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [33:0] fs_to_ds_bus;

  if_stage #(.FS_TO_DS_BUS_WD(34), .RESET_PC(32'h1c000000)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .fs_to_ds_bus   (fs_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        en;
    logic [31:0] addr;
    logic [33:0] bus;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  function automatic logic [33:0] mk(input logic v, input logic a, input logic [31:0] pc);
    return {v, a, pc};
  endfunction

  task automatic step(input logic rst, input logic fl, input logic [31:0] npc,
                      input logic st, input logic br, input logic [31:0] bt,
                      input logic e_en, input logic [31:0] e_addr, input logic [33:0] e_bus);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    flush     = fl;
    new_pc    = npc;
    stall     = {5'b0, st};
    br_taken  = br;
    br_target = bt;
    e.idx  = step_no;
    e.en   = e_en;
    e.addr = e_addr;
    e.bus  = e_bus;
    exp_q.push_back(e);
    step_no++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (inst_sram_en !== e.en) begin
        n_bad++;
        $display("FAIL en step %0d: got %0b expected %0b", e.idx, inst_sram_en, e.en);
      end
      n_cmp++;
      if (inst_sram_addr !== e.addr) begin
        n_bad++;
        $display("FAIL addr step %0d: got %h expected %h", e.idx, inst_sram_addr, e.addr);
      end
      n_cmp++;
      if (fs_to_ds_bus !== e.bus) begin
        n_bad++;
        $display("FAIL bus step %0d: got %h expected %h", e.idx, fs_to_ds_bus, e.bus);
      end
      n_cmp++;
      if (inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'b0) begin
        n_bad++;
        $display("FAIL wr_tie step %0d: got we=%h wdata=%h expected 0/0", e.idx, inst_sram_we, inst_sram_wdata);
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; new_pc = 32'b0; stall = 6'b0;
    br_taken = 1'b0; br_target = 32'b0;
    //     rst  fl  new_pc         st  br  br_target      en  addr           bus
    step(1'b1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000000, mk(0, 0, 32'h1bfffffc));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000000, mk(0, 0, 32'h1bfffffc));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000004, mk(1, 0, 32'h1c000000));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000008, mk(1, 0, 32'h1c000004));
    // stall held three cycles at pc 1c000008
    for (int i = 0; i < 3; i++)
      step(1'b0, 0, 32'h0,      1, 0, 32'h0,        0, 32'h1c00000c, mk(1, 0, 32'h1c000008));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c00000c, mk(1, 0, 32'h1c000008));
    // taken branch without stall
    step(1'b0, 0, 32'h0,        0, 1, 32'h1c000100, 1, 32'h1c000100, mk(1, 0, 32'h1c00000c));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000104, mk(1, 0, 32'h1c000100));
    // two branches while stalled: newest wins
    step(1'b0, 0, 32'h0,        1, 1, 32'h1c000200, 0, 32'h1c000200, mk(1, 0, 32'h1c000104));
    step(1'b0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000200, mk(1, 0, 32'h1c000104));
    step(1'b0, 0, 32'h0,        1, 1, 32'h1c000300, 0, 32'h1c000300, mk(1, 0, 32'h1c000104));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000300, mk(1, 0, 32'h1c000104));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000304, mk(1, 0, 32'h1c000300));
    // flush while stalled with a branch pending
    step(1'b0, 0, 32'h0,        1, 1, 32'h1c000400, 0, 32'h1c000400, mk(1, 0, 32'h1c000304));
    step(1'b0, 1, 32'h1c008000, 1, 0, 32'h0,        1, 32'h1c008000, mk(1, 0, 32'h1c000304));
    step(1'b0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h1c008004, mk(1, 0, 32'h1c008000));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c008004, mk(1, 0, 32'h1c008000));
    // misaligned flush target, simultaneous branch dropped
    step(1'b0, 1, 32'h1c000002, 0, 1, 32'h1c000500, 0, 32'h1c000002, mk(1, 0, 32'h1c008004));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h1c000006, mk(1, 1, 32'h1c000002));
    step(1'b0, 0, 32'h0,        1, 1, 32'h1c000600, 0, 32'h1c000600, mk(1, 1, 32'h1c000006));
    // async reset mid-sequence clears the pending branch too
    step(1'b1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000000, mk(0, 0, 32'h1bfffffc));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000000, mk(0, 0, 32'h1bfffffc));
    step(1'b0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000004, mk(1, 0, 32'h1c000000));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
